sha2_compress_core: RTL and testbench

Parametrised SHA-224/SHA-256 chunk compression engine: successor to the one-round-per-clock compressor, with a start/busy/done handshake, an internal round counter, a selectable unroll factor, a SHA-224 initial-value mode and a synchronous abort. It sits between the message-schedule block, which supplies W[t] and K[t] addressed by `rnd_idx`, and the AXI register file that reads `digest`.

---
 rtl/sha2_compress_core.sv | 164 ++++++++++++++++
 tb/tb_sha2_compress_core.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_compress_core.sv
// sha2_compress_core
//   SHA-224/SHA-256 chunk compression engine. UNROLL rounds are applied per
//   clock. The chaining value H is held here and is exposed on `digest`.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             begin a chunk (accepted only in IDLE, and only without abort)
//   init              with start: 1 = load IV into H and a..h, 0 = continue from H
//   mode_224          with start and init: 1 = SHA-224 IV, 0 = SHA-256 IV
//   abort             abandon the chunk in progress (ROUND only)
//   w_in, k_in        W[t]/K[t] for rounds rnd_idx+j in slice j
//   rnd_idx           first round consumed this cycle
//   busy              high in ROUND and FINAL
//   done              one-cycle pulse after H has been updated
//   digest            H0..H7, H0 in the top word, optionally byte-swapped per word
//   dbg_state         current FSM state (IDLE=0, ROUND=1, FINAL=2)
//
// Handshake: start is a level sampled on the clock edge while the engine is
// IDLE. There is no ready signal. A start seen while busy is dropped and not
// queued. done is high for exactly one cycle, and a start in that cycle is
// accepted.
//
// UNROLL must be 1, 2, 4 or 8 so that 64 rounds split evenly into round cycles.
module sha2_compress_core #(
    parameter int UNROLL    = 1,
    parameter bit BYTE_SWAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 init,
    input  logic                 mode_224,
    input  logic                 abort,
    input  logic [32*UNROLL-1:0] w_in,
    input  logic [32*UNROLL-1:0] k_in,
    output logic [5:0]           rnd_idx,
    output logic                 busy,
    output logic                 done,
    output logic [255:0]         digest,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    localparam logic [255:0] IV_256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV_224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [5:0]   STEP     = 6'(UNROLL);
    localparam logic [5:0]   LAST_IDX = 6'(64 - UNROLL);

    state_t       state_q;
    logic [5:0]   rnd_q;
    logic         done_q;
    logic [31:0]  h_q  [8];
    logic [31:0]  wk_q [8];   // working variables a..h, index 0 = a
    logic [31:0]  wk_d [8];   // working variables after this cycle's rounds
    logic [31:0]  t1, t2;
    logic [255:0] iv_sel;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    assign iv_sel = mode_224 ? IV_224 : IV_256;

    // UNROLL rounds are chained combinationally. Slice j feeds round rnd_idx+j.
    always_comb begin
        t1 = '0;
        t2 = '0;
        for (int i = 0; i < 8; i++) wk_d[i] = wk_q[i];
        for (int j = 0; j < UNROLL; j++) begin
            t1 = wk_d[7] + big_sig1(wk_d[4])
               + ((wk_d[4] & wk_d[5]) ^ (~wk_d[4] & wk_d[6]))
               + k_in[32*j +: 32] + w_in[32*j +: 32];
            t2 = big_sig0(wk_d[0])
               + ((wk_d[0] & wk_d[1]) ^ (wk_d[0] & wk_d[2]) ^ (wk_d[1] & wk_d[2]));
            wk_d[7] = wk_d[6];
            wk_d[6] = wk_d[5];
            wk_d[5] = wk_d[4];
            wk_d[4] = wk_d[3] + t1;
            wk_d[3] = wk_d[2];
            wk_d[2] = wk_d[1];
            wk_d[1] = wk_d[0];
            wk_d[0] = t1 + t2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= IV_256[255-32*i -: 32];
                wk_q[i] <= IV_256[255-32*i -: 32];
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // abort blocks a start in the same cycle
                    if (start && !abort) begin
                        state_q <= S_ROUND;
                        rnd_q   <= '0;
                        for (int i = 0; i < 8; i++) begin
                            if (init) begin
                                h_q[i]  <= iv_sel[255-32*i -: 32];
                                wk_q[i] <= iv_sel[255-32*i -: 32];
                            end else begin
                                wk_q[i] <= h_q[i];
                            end
                        end
                    end
                end
                S_ROUND: begin
                    if (abort) begin
                        // H is untouched, so a later init=0 chunk resumes cleanly
                        state_q <= S_IDLE;
                        rnd_q   <= '0;
                    end else begin
                        for (int i = 0; i < 8; i++) wk_q[i] <= wk_d[i];
                        if (rnd_q == LAST_IDX) begin
                            state_q <= S_FINAL;
                            rnd_q   <= '0;
                        end else begin
                            rnd_q <= rnd_q + STEP;
                        end
                    end
                end
                S_FINAL: begin
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + wk_q[i];
                    state_q <= S_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_digest
        if (BYTE_SWAP) begin : g_swap
            assign digest[255-32*i -: 32] = {h_q[i][7:0], h_q[i][15:8], h_q[i][23:16], h_q[i][31:24]};
        end else begin : g_native
            assign digest[255-32*i -: 32] = h_q[i];
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign rnd_idx   = rnd_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sha2_compress_core.sv
// Bench for sha2_compress_core. There is one lane per unroll factor (1, 2, 4, 8).
// Lanes with an odd index run with BYTE_SWAP=1. Each lane has its own driver,
// its own schedule feeder and its own scoreboard. The expected digests come
// from known SHA-256/224 vectors or from a plain software SHA-256 compression
// function.
module tb_sha2_compress_core;

    localparam logic [255:0] IV256  = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] IV224  = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
    localparam logic [255:0] ABC256 = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [223:0] ABC224 = 224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7;
    localparam logic [255:0] TWO256 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] BLK_ABC  = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
    localparam logic [511:0] BLK_TWO1 = 512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] BLK_TWO2 = {{15{32'h00000000}}, 32'h000001c0};

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic clk;
    int   cyc;
    int   n_checks;
    int   n_fail;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full 64-word message schedule, W[0] in the top word.
    function automatic logic [2047:0] expand(input logic [511:0] blk);
        logic [31:0]   w [64];
        logic [31:0]   s0, s1;
        logic [2047:0] r;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        for (int t = 0; t < 64; t++) r[2047-32*t -: 32] = w[t];
        return r;
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [2047:0] ws;
        logic [31:0]   v [8];
        logic [31:0]   a1, a2;
        logic [255:0]  r;
        ws = expand(blk);
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            a1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TAB[t] + ws[2047-32*t -: 32];
            a2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + a1;
            v[0] = a1 + a2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return r;
    endfunction

    // Host-side view of a digest: each word byte-reversed when bs is set.
    function automatic logic [255:0] host_view(input logic [255:0] x, input bit bs);
        logic [255:0] r;
        r = x;
        if (bs)
            for (int i = 0; i < 8; i++)
                for (int b = 0; b < 4; b++)
                    r[32*i + 8*b +: 8] = x[32*i + 8*(3-b) +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- lanes ----------------
    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int U  = 1 << g;
        localparam bit BS = (g % 2) == 1;
        localparam int N  = 64 / U;

        logic              rst_n_l, start_l, init_l, m224_l, abort_l;
        logic [32*U-1:0]   w_l, k_l;
        logic [5:0]        idx_l;
        logic              busy_l, done_l;
        logic [255:0]      dig_l;
        logic [1:0]        st_l;
        logic [2047:0]     wexp;
        logic              fin_l;
        logic [255:0]      hmod;
        logic [511:0]      blk;
        logic [255:0]      exp_q [$];
        int                cyc_q [$];
        logic [255:0]      mon_e;
        int                mon_c;

        sha2_compress_core #(.UNROLL(U), .BYTE_SWAP(BS)) dut (
            .clk       (clk),
            .rst_n     (rst_n_l),
            .start     (start_l),
            .init      (init_l),
            .mode_224  (m224_l),
            .abort     (abort_l),
            .w_in      (w_l),
            .k_in      (k_l),
            .rnd_idx   (idx_l),
            .busy      (busy_l),
            .done      (done_l),
            .digest    (dig_l),
            .dbg_state (st_l)
        );

        // Message schedule stand-in: answers rnd_idx in the same cycle.
        always_comb begin
            w_l = '0;
            k_l = '0;
            for (int j = 0; j < U; j++) begin
                w_l[32*j +: 32] = wexp[32*(63 - ((int'(idx_l) + j) % 64)) +: 32];
                k_l[32*j +: 32] = K_TAB[(int'(idx_l) + j) % 64];
            end
        end

        // Scoreboard monitor
        always @(negedge clk) begin
            if (done_l) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("lane%0d unexpected done", g), 256'(done_l), 256'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_c = cyc_q.pop_front();
                    check($sformatf("lane%0d digest", g), dig_l, mon_e);
                    check($sformatf("lane%0d done cycle", g), 256'(cyc), 256'(mon_c));
                    check($sformatf("lane%0d busy at done", g), 256'(busy_l), 256'd0);
                end
            end
        end

        task automatic tick();
            @(posedge clk);
            #1;
        endtask

        task automatic issue(input logic [511:0] b, input logic ini, input logic m,
                             input logic push, input logic [255:0] exp);
            wexp    = expand(b);
            start_l = 1'b1;
            init_l  = ini;
            m224_l  = m;
            tick();
            start_l = 1'b0;
            init_l  = 1'b0;
            m224_l  = 1'b0;
            if (push) begin
                exp_q.push_back(exp);
                cyc_q.push_back(cyc + N + 1);
            end
        endtask

        // Chunk whose expected result comes from the software model.
        task automatic chunk(input logic [511:0] b, input logic ini, input logic m);
            logic [255:0] base;
            base = ini ? (m ? IV224 : IV256) : hmod;
            hmod = ref_compress(base, b);
            issue(b, ini, m, 1'b1, host_view(hmod, BS));
        endtask

        task automatic wait_done(input string what);
            for (int k = 0; k < 200 && !done_l; k++) tick();
            check($sformatf("lane%0d %s done seen", g, what), 256'(done_l), 256'd1);
        endtask

        task automatic wait_drain(input string what);
            for (int k = 0; k < 300 && exp_q.size() != 0; k++) tick();
            check($sformatf("lane%0d %s drained", g, what), 256'(exp_q.size()), 256'd0);
            exp_q.delete();
            cyc_q.delete();
        endtask

        task automatic rand_blk();
            for (int i = 0; i < 16; i++) blk[32*i +: 32] = $urandom();
        endtask

        initial begin
            rst_n_l = 1'b0;
            start_l = 1'b0;
            init_l  = 1'b0;
            m224_l  = 1'b0;
            abort_l = 1'b0;
            wexp    = '0;
            fin_l   = 1'b0;
            hmod    = IV256;
            repeat (3) tick();
            rst_n_l = 1'b1;
            tick();
            check($sformatf("lane%0d reset digest", g), dig_l, host_view(IV256, BS));
            check($sformatf("lane%0d reset busy", g), 256'(busy_l), 256'd0);
            check($sformatf("lane%0d reset done", g), 256'(done_l), 256'd0);
            check($sformatf("lane%0d reset rnd_idx", g), 256'(idx_l), 256'd0);

            // Known vectors
            issue(BLK_ABC, 1'b1, 1'b0, 1'b1, host_view(ABC256, BS));
            hmod = ABC256;
            wait_drain("abc256");
            hmod = ref_compress(IV224, BLK_ABC);
            issue(BLK_ABC, 1'b1, 1'b1, 1'b1, host_view({ABC224, hmod[31:0]}, BS));
            hmod = {ABC224, hmod[31:0]};
            wait_drain("abc224");

            // Two-chunk message, second start issued in the done cycle
            chunk(BLK_TWO1, 1'b1, 1'b0);
            wait_done("two/1");
            issue(BLK_TWO2, 1'b0, 1'b0, 1'b1, host_view(TWO256, BS));
            hmod = TWO256;
            wait_drain("two/2");

            // Random chunks, sometimes back-to-back
            for (int r = 0; r < 6; r++) begin
                rand_blk();
                chunk(blk, (r == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1) begin
                    wait_done("random");
                end else begin
                    wait_drain("random");
                    repeat ($urandom_range(0, 3)) tick();
                end
            end
            wait_drain("random tail");

            // Abort at round 30 (first round index at or above 30 for wider unrolls)
            rand_blk();
            issue(blk, 1'b0, 1'b0, 1'b0, '0);
            for (int k = 0; k < 100 && idx_l < 6'd30; k++) tick();
            abort_l = 1'b1;
            tick();
            abort_l = 1'b0;
            check($sformatf("lane%0d abort busy", g), 256'(busy_l), 256'd0);
            check($sformatf("lane%0d abort rnd_idx", g), 256'(idx_l), 256'd0);
            repeat (80) tick();
            check($sformatf("lane%0d abort digest", g), dig_l, host_view(hmod, BS));

            // Abort on the last round cycle beats the move to FINAL
            issue(blk, 1'b0, 1'b0, 1'b0, '0);
            for (int k = 0; k < 100 && idx_l != 6'(64 - U); k++) tick();
            abort_l = 1'b1;
            tick();
            abort_l = 1'b0;
            check($sformatf("lane%0d late abort busy", g), 256'(busy_l), 256'd0);
            repeat (5) tick();
            check($sformatf("lane%0d late abort digest", g), dig_l, host_view(hmod, BS));

            // Abort together with start in IDLE: nothing starts
            abort_l = 1'b1;
            start_l = 1'b1;
            init_l  = 1'b1;
            tick();
            abort_l = 1'b0;
            start_l = 1'b0;
            init_l  = 1'b0;
            check($sformatf("lane%0d abort+start busy", g), 256'(busy_l), 256'd0);
            repeat (3) tick();
            check($sformatf("lane%0d abort+start digest", g), dig_l, host_view(hmod, BS));

            // Continue after the aborts from the untouched H; a start while busy is dropped
            rand_blk();
            chunk(blk, 1'b0, 1'b0);
            repeat (N / 2) tick();
            start_l = 1'b1;
            init_l  = 1'b1;
            m224_l  = 1'b1;
            tick();
            start_l = 1'b0;
            init_l  = 1'b0;
            m224_l  = 1'b0;
            wait_drain("start while busy");
            repeat (3) tick();

            // Reset in the middle of a chunk
            rand_blk();
            issue(blk, 1'b0, 1'b0, 1'b0, '0);
            for (int k = 0; k < 100 && idx_l < 6'd40; k++) tick();
            #1;
            rst_n_l = 1'b0;
            #1;
            check($sformatf("lane%0d async reset busy", g), 256'(busy_l), 256'd0);
            check($sformatf("lane%0d async reset digest", g), dig_l, host_view(IV256, BS));
            tick();
            rst_n_l = 1'b1;
            tick();
            repeat (70) tick();
            issue(BLK_ABC, 1'b1, 1'b0, 1'b1, host_view(ABC256, BS));
            wait_drain("abc after reset");
            fin_l = 1'b1;
        end
    end

    initial begin
        logic [3:0] fin;
        fin = '0;
        for (int k = 0; k < 60000 && fin != 4'hf; k++) begin
            @(posedge clk);
            fin = {lane[3].fin_l, lane[2].fin_l, lane[1].fin_l, lane[0].fin_l};
        end
        check("all lanes finished", 256'(fin), 256'hf);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
